serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial adder, one bit per clock, LSB first, 3-state FSM.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  logic             w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_res_shift;
  logic             w_unused;

  assign w_sum       = a_q[0] ^ b_q[0] ^ c_q;
  assign w_carry     = (a_q[0] & b_q[0]) | (b_q[0] & c_q) | (c_q & a_q[0]);
  assign w_res_shift = {w_sum, res_q[WIDTH-1:1]};
  // Oldest result bit falls off the end of the shift register each cycle.
  assign w_unused    = res_q[0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          c_d     = CIN;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        res_d = w_res_shift;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = w_carry;
        if (cnt_q == C_LAST) begin
          // Counter holds at its last value so it never wraps mid-operation.
          state_d = ST_DONE;
          s_d     = w_res_shift;
          cout_d  = w_carry;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_DONE);
  assign S    = s_q;
  assign COUT = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Self-checking bench for serial_adder against an arithmetic model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             CIN = 1'b0;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             COUT;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_done_cyc = -1;

  logic [WIDTH-1:0] exp_s = '0;
  logic             exp_c = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S),
    .COUT  (COUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // mode 0: quiet inputs during RUN; 1: random noise incl. START; 2: START held high;
  // 3: new operands + START in RUN cycle 4 only.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int mode);
    logic [WIDTH:0] full;
    full = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    START = 1'b1; A = a; B = b; CIN = cin;
    tick();
    if (mode != 2) START = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      chk("busy_run", {31'd0, BUSY}, 32'd1);
      chk("done_run", {31'd0, DONE}, 32'd0);
      chk("s_hold",   {24'd0, S}, {24'd0, exp_s});
      chk("c_hold",   {31'd0, COUT}, {31'd0, exp_c});
      if (mode == 1) begin
        A = WIDTH'($urandom); B = WIDTH'($urandom); CIN = 1'($urandom); START = 1'($urandom);
      end else if (mode == 3) begin
        START = (i == 4); A = ~a; B = a ^ b; CIN = ~cin;
      end
      tick();
    end
    START = 1'b0;
    exp_s = full[WIDTH-1:0];
    exp_c = full[WIDTH];
    chk("done_pulse", {31'd0, DONE}, 32'd1);
    chk("busy_done",  {31'd0, BUSY}, 32'd0);
    chk("sum",        {24'd0, S}, {24'd0, exp_s});
    chk("cout",       {31'd0, COUT}, {31'd0, exp_c});
    if (mode == 2 && last_done_cyc >= 0)
      chk("done_spacing", 32'(cyc - last_done_cyc), 32'(WIDTH + 1));
    last_done_cyc = cyc;
  endtask

  task automatic idle_cycles(input int n);
    START = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      chk("idle_busy", {31'd0, BUSY}, 32'd0);
      chk("idle_done", {31'd0, DONE}, 32'd0);
      chk("idle_s",    {24'd0, S}, {24'd0, exp_s});
      chk("idle_c",    {31'd0, COUT}, {31'd0, exp_c});
      A = WIDTH'($urandom); B = WIDTH'($urandom); CIN = 1'($urandom);
      tick();
    end
    last_done_cyc = -1;
  endtask

  initial begin
    RST = 1'b1;
    tick(); tick();
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_s",    {24'd0, S}, 32'd0);
    chk("rst_c",    {31'd0, COUT}, 32'd0);
    RST = 1'b0;

    // Accepted on the very first edge after reset release.
    run_op(8'h5A, 8'h33, 1'b0, 0);
    if (S !== 8'h8D || COUT !== 1'b0) begin
      miscompares++;
      $error("FAIL directed_5a_33 observed=0x%0h/%0b expected=0x8d/0", S, COUT);
    end
    vectors++;
    idle_cycles(3);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    idle_cycles(2);

    // Continuous START: back-to-back operations from DONE.
    last_done_cyc = -1;
    for (int k = 0; k < 4; k++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 2);
    idle_cycles(2);

    // START with new operands in RUN cycle 4 must not disturb the operation.
    run_op(8'h12, 8'hE7, 1'b1, 3);
    idle_cycles(1);

    // Reset during RUN cycle 3 aborts without a DONE pulse.
    START = 1'b1; A = 8'hA5; B = 8'h5A; CIN = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick();
    chk("pre_abort_busy", {31'd0, BUSY}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_s = '0; exp_c = 1'b0;
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_done", {31'd0, DONE}, 32'd0);
    chk("abort_s",    {24'd0, S}, 32'd0);
    chk("abort_c",    {31'd0, COUT}, 32'd0);
    for (int i = 0; i < WIDTH + 3; i++) begin
      chk("abort_no_done", {31'd0, DONE}, 32'd0);
      tick();
    end
    run_op(8'h80, 8'h80, 1'b1, 0);

    // Randomized operations with mixed input activity.
    for (int k = 0; k < 20; k++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
